// File: rtl/pll_phase_step_ctrl.sv
// PLL dynamic phase-adjust initiator: issues PHASE_STEP_N pulse trains for accepted
// commands, waits for re-lock and keeps a signed phase offset per PLL output.
module pll_phase_step_ctrl #(
   parameter int NUM_CH    = 5,
   parameter int SETUP_CYC = 2,
   parameter int LOW_CYC   = 4,
   parameter int GAP_CYC   = 4,
   parameter int LOCK_TO   = 50000,
   parameter int OFS_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_sel,
   input  logic             cmd_dir,
   input  logic [7:0]       cmd_steps,
   input  logic             pll_lock,
   output logic [2:0]       phase_sel,
   output logic             phase_dir,
   output logic             phase_step_n,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic             err_sel,
   input  logic [2:0]       rd_sel,
   output logic [OFS_W-1:0] rd_offset
);

   localparam int CNT_MAX_A = (SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC;
   localparam int CNT_MAX_B = (GAP_CYC > LOCK_TO) ? GAP_CYC : LOCK_TO;
   localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
   localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(LOW_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   // The counter reaches LOCK_TO-1 on the exit edge, so the decision is taken one value earlier.
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TO - 2);
   localparam logic [3:0]       NUM_CH_L   = 4'(NUM_CH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SETUP     = 3'd1,
      S_STEP_LO   = 3'd2,
      S_STEP_HI   = 3'd3,
      S_WAIT_LOCK = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [7:0]       rem_r;
   logic [7:0]       rem_nxt_s;
   logic [7:0]       steps_r;
   logic [2:0]       sel_r;
   logic             dir_r;
   logic             lock_meta_r;
   logic             lock_sync_r;

   logic             accept_s;
   logic             bad_sel_s;
   logic             zero_s;
   logic             start_s;
   logic             lock_exit_s;
   logic             to_exit_s;
   logic             exit_s;
   logic             step_n_nxt_s;
   logic             busy_nxt_s;

   logic             step_n_r;
   logic             busy_r;
   logic             done_p_r;
   logic             done_r;
   logic             to_p_r;
   logic             to_r;
   logic             esel_p_r;
   logic             esel_r;

   logic [OFS_W-1:0] ofs_r [NUM_CH];
   logic [OFS_W-1:0] ofs_cur_s;
   logic [OFS_W-1:0] ofs_nxt_s;
   logic [OFS_W-1:0] mag_s;

   assign cmd_ready    = (state_r == S_IDLE) && lock_sync_r;
   assign phase_sel    = sel_r;
   assign phase_dir    = dir_r;
   assign phase_step_n = step_n_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err_timeout  = to_r;
   assign err_sel      = esel_r;

   // Two-flop synchroniser for the asynchronous lock indication.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= pll_lock;
         lock_sync_r <= lock_meta_r;
      end
   end

   // State register with the shared phase counter and remaining-step count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= CNT_ZERO;
         rem_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         rem_r   <= rem_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rem_nxt_s   = rem_r;
      case (state_r)
         S_IDLE: begin
            cnt_nxt_s = CNT_ZERO;
            if (start_s) begin
               state_nxt_s = S_SETUP;
               rem_nxt_s   = cmd_steps;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_nxt_s = S_STEP_LO;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         S_STEP_LO: begin
            if (cnt_r == LOW_LAST) begin
               state_nxt_s = S_STEP_HI;
               cnt_nxt_s   = CNT_ZERO;
               rem_nxt_s   = rem_r - 8'd1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         S_STEP_HI: begin
            if (cnt_r == GAP_LAST) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = (rem_r != 8'd0) ? S_STEP_LO : S_WAIT_LOCK;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_exit_s || to_exit_s) begin
               state_nxt_s = S_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            rem_nxt_s   = 8'd0;
         end
      endcase
   end

   // Output decode: command outcomes and next values of the registered outputs.
   always_comb begin
      accept_s     = cmd_valid && cmd_ready;
      bad_sel_s    = accept_s && ({1'b0, cmd_sel} >= NUM_CH_L);
      zero_s       = accept_s && !bad_sel_s && (cmd_steps == 8'd0);
      start_s      = accept_s && !bad_sel_s && (cmd_steps != 8'd0);
      lock_exit_s  = (state_r == S_WAIT_LOCK) && lock_sync_r;
      to_exit_s    = (state_r == S_WAIT_LOCK) && !lock_sync_r && (cnt_r == TO_LAST);
      exit_s       = lock_exit_s || to_exit_s;
      step_n_nxt_s = (state_nxt_s != S_STEP_LO);
      busy_nxt_s   = (state_nxt_s != S_IDLE);
   end

   // Registered outputs; status pulses appear the cycle after the deciding edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_n_r <= 1'b1;
         busy_r   <= 1'b0;
         done_p_r <= 1'b0;
         done_r   <= 1'b0;
         to_p_r   <= 1'b0;
         to_r     <= 1'b0;
         esel_p_r <= 1'b0;
         esel_r   <= 1'b0;
      end else begin
         step_n_r <= step_n_nxt_s;
         busy_r   <= busy_nxt_s;
         done_p_r <= zero_s || lock_exit_s;
         done_r   <= done_p_r;
         to_p_r   <= to_exit_s;
         to_r     <= to_p_r;
         esel_p_r <= bad_sel_s;
         esel_r   <= esel_p_r;
      end
   end

   // Command latch; sel/dir stay on the PLL pins until the next started command.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_r   <= 3'd0;
         dir_r   <= 1'b0;
         steps_r <= 8'd0;
      end else if (start_s) begin
         sel_r   <= cmd_sel;
         dir_r   <= cmd_dir;
         steps_r <= cmd_steps;
      end else begin
         sel_r   <= sel_r;
         dir_r   <= dir_r;
         steps_r <= steps_r;
      end
   end

   // Offset arithmetic wraps modulo 2^OFS_W.
   always_comb begin
      ofs_cur_s = {OFS_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         ofs_cur_s = (sel_r == 3'(i)) ? ofs_r[i] : ofs_cur_s;
      end
      mag_s     = OFS_W'(steps_r);
      ofs_nxt_s = dir_r ? (ofs_cur_s + mag_s) : (ofs_cur_s - mag_s);
   end

   // Offsets only change once every step of a command has been issued.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            ofs_r[i] <= {OFS_W{1'b0}};
         end else if (exit_s && (sel_r == 3'(i))) begin
            ofs_r[i] <= ofs_nxt_s;
         end else begin
            ofs_r[i] <= ofs_r[i];
         end
      end
   end

   always_comb begin
      rd_offset = {OFS_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         rd_offset = (rd_sel == 3'(i)) ? ofs_r[i] : rd_offset;
      end
   end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Scoreboard bench for pll_phase_step_ctrl: expected step edges and status pulses are
// queued with their cycle of occurrence at command time and matched as the DUT emits them.
module tb_pll_phase_step_ctrl;

   localparam int NUM_CH    = 5;
   localparam int SETUP_CYC = 2;
   localparam int LOW_CYC   = 4;
   localparam int GAP_CYC   = 4;
   localparam int LOCK_TO   = 100;
   localparam int OFS_W     = 12;
   localparam int STEP_CYC  = LOW_CYC + GAP_CYC;

   localparam int EV_FALL = 0;
   localparam int EV_RISE = 1;
   localparam int EV_DONE = 2;
   localparam int EV_TO   = 3;
   localparam int EV_SEL  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_sel;
   logic             cmd_dir;
   logic [7:0]       cmd_steps;
   logic             pll_lock;
   logic [2:0]       phase_sel;
   logic             phase_dir;
   logic             phase_step_n;
   logic             busy;
   logic             done;
   logic             err_timeout;
   logic             err_sel;
   logic [2:0]       rd_sel;
   logic [OFS_W-1:0] rd_offset;

   typedef struct {
      int kind;
      int at;
   } ev_t;

   ev_t              sb[$];
   int               cyc = 0;
   int               vectors = 0;
   int               miscompares = 0;
   logic [OFS_W-1:0] mdl_ofs [8];
   logic [2:0]       mdl_sel;
   logic             mdl_dir;

   pll_phase_step_ctrl #(
      .NUM_CH(NUM_CH), .SETUP_CYC(SETUP_CYC), .LOW_CYC(LOW_CYC),
      .GAP_CYC(GAP_CYC), .LOCK_TO(LOCK_TO), .OFS_W(OFS_W)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
      .pll_lock(pll_lock), .phase_sel(phase_sel), .phase_dir(phase_dir),
      .phase_step_n(phase_step_n), .busy(busy), .done(done),
      .err_timeout(err_timeout), .err_sel(err_sel), .rd_sel(rd_sel),
      .rd_offset(rd_offset)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      sb.push_back(e);
   endtask

   // Issue one command, queue its expected events and match them against the DUT.
   task automatic run_cmd(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                          input bit drop_lock, input string name);
      int   acc;
      int   budget;
      int   quiet;
      int   n;
      bit   ok;
      logic prev_n;
      ev_t  e;
      int   obs[$];
      n = int'(steps);
      cmd_sel   = sel;
      cmd_dir   = dir;
      cmd_steps = steps;
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cmd_ready === 1'b1) ok = 1'b1;
         else tick();
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s accept: cmd_ready=%b after 50 cycles, required 1", name, cmd_ready);
         cmd_valid = 1'b0;
         return;
      end
      tick();
      acc = cyc;
      cmd_valid = 1'b0;
      if (int'(sel) >= NUM_CH) begin
         expect_ev(EV_SEL, acc + 1);
      end else if (n == 0) begin
         expect_ev(EV_DONE, acc + 1);
      end else begin
         for (int i = 0; i < n; i++) begin
            expect_ev(EV_FALL, acc + SETUP_CYC + i * STEP_CYC);
            expect_ev(EV_RISE, acc + SETUP_CYC + i * STEP_CYC + LOW_CYC);
         end
         if (drop_lock) expect_ev(EV_TO, acc + SETUP_CYC + n * STEP_CYC + LOCK_TO);
         else expect_ev(EV_DONE, acc + SETUP_CYC + n * STEP_CYC + 2);
         mdl_sel = sel;
         mdl_dir = dir;
         mdl_ofs[sel] = dir ? (mdl_ofs[sel] + OFS_W'(steps)) : (mdl_ofs[sel] - OFS_W'(steps));
         if (drop_lock) pll_lock = 1'b0;
      end
      prev_n = 1'b1;
      budget = SETUP_CYC + n * STEP_CYC + LOCK_TO + 20;
      quiet  = 0;
      for (int k = 0; k < budget && quiet < 4; k++) begin
         obs = {};
         if (phase_step_n !== prev_n) obs.push_back((phase_step_n === 1'b0) ? EV_FALL : EV_RISE);
         prev_n = phase_step_n;
         if (done === 1'b1) obs.push_back(EV_DONE);
         if (err_timeout === 1'b1) obs.push_back(EV_TO);
         if (err_sel === 1'b1) obs.push_back(EV_SEL);
         foreach (obs[j]) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL %s unexpected: event %0d at +%0d, required none", name, obs[j], cyc - acc);
            end else begin
               e = sb.pop_front();
               if (obs[j] != e.kind || cyc != e.at) begin
                  miscompares++;
                  $display("FAIL %s event: got kind %0d at +%0d, required kind %0d at +%0d",
                           name, obs[j], cyc - acc, e.kind, e.at - acc);
               end
            end
            if (obs[j] == EV_FALL) begin
               vectors++;
               if (phase_sel !== mdl_sel || phase_dir !== mdl_dir || busy !== 1'b1) begin
                  miscompares++;
                  $display("FAIL %s pins: sel=%0d dir=%b busy=%b, required sel=%0d dir=%b busy=1",
                           name, phase_sel, phase_dir, busy, mdl_sel, mdl_dir);
               end
            end
         end
         if (sb.size() == 0) quiet++;
         tick();
      end
      vectors++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s completion: %0d events outstanding busy=%b, required 0 and busy=0",
                  name, sb.size(), busy);
         sb.delete();
      end
      if (drop_lock) begin
         pll_lock = 1'b1;
         repeat (3) tick();
      end
   endtask

   task automatic check_offsets(input string name);
      for (int ch = 0; ch < 8; ch++) begin
         rd_sel = 3'(ch);
         #1;
         vectors++;
         if (rd_offset !== mdl_ofs[ch]) begin
            miscompares++;
            $display("FAIL %s offset[%0d]: got 0x%03h, required 0x%03h", name, ch, rd_offset, mdl_ofs[ch]);
         end
      end
      tick();
   endtask

   task automatic check_one(input logic [2:0] ch, input logic [OFS_W-1:0] req, input string name);
      rd_sel = ch;
      #1;
      vectors++;
      if (rd_offset !== req) begin
         miscompares++;
         $display("FAIL %s rd_offset[%0d]: got 0x%03h, required 0x%03h", name, ch, rd_offset, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) tick();
      vectors++;
      if (phase_step_n !== 1'b1 || phase_sel !== 3'd0 || phase_dir !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || err_timeout !== 1'b0 || err_sel !== 1'b0 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: step_n=%b sel=%0d dir=%b busy=%b done=%b to=%b esel=%b rdy=%b, required 1 0 0 0 0 0 0 0",
                  phase_step_n, phase_sel, phase_dir, busy, done, err_timeout, err_sel, cmd_ready);
      end
      rst = 1'b0;
      repeat (3) tick();
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
      end
      check_offsets("reset");
   endtask

   task automatic test_step_advance();
      run_cmd(3'd2, 1'b1, 8'd3, 1'b0, "adv3");
      check_one(3'd2, 12'h003, "adv3");
      check_offsets("adv3");
   endtask

   task automatic test_step_retard();
      run_cmd(3'd2, 1'b0, 8'd5, 1'b0, "ret5");
      check_one(3'd2, 12'hFFE, "ret5");
      check_offsets("ret5");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8; i++) run_cmd(3'd0, 1'b0, 8'd255, 1'b0, "wrap255");
      run_cmd(3'd0, 1'b0, 8'd8, 1'b0, "wrap8");
      check_one(3'd0, 12'h800, "wrap_min");
      run_cmd(3'd0, 1'b0, 8'd1, 1'b0, "wrap1");
      check_one(3'd0, 12'h7FF, "wrap_over");
      check_offsets("wrap");
   endtask

   task automatic test_timeout();
      run_cmd(3'd4, 1'b1, 8'd3, 1'b1, "timeout");
      check_one(3'd4, 12'h003, "timeout");
      check_offsets("timeout");
   endtask

   task automatic test_sel_and_zero();
      run_cmd(3'd6, 1'b0, 8'd3, 1'b0, "bad_sel");
      vectors++;
      if (phase_sel !== 3'd4 || phase_dir !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_sel_pins: sel=%0d dir=%b, required 4 1", phase_sel, phase_dir);
      end
      run_cmd(3'd1, 1'b0, 8'd0, 1'b0, "zero_steps");
      check_offsets("sel_zero");
      pll_lock  = 1'b0;
      repeat (4) tick();
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_sel   = (i < 3) ? 3'd6 : 3'd1;
         cmd_steps = 8'd0;
         tick();
         vectors++;
         if (cmd_ready !== 1'b0 || err_sel !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL unlocked_ignore: rdy=%b esel=%b done=%b, required 0 0 0", cmd_ready, err_sel, done);
         end
      end
      cmd_valid = 1'b0;
      pll_lock  = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      int acc;
      bit ok;
      cmd_sel   = 3'd3;
      cmd_dir   = 1'b1;
      cmd_steps = 8'd3;
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cmd_ready === 1'b1) ok = 1'b1;
         else tick();
      end
      tick();
      acc = cyc;
      cmd_valid = 1'b0;
      while (cyc < acc + 11) tick();
      vectors++;
      if (!ok || phase_step_n !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_step_low: accepted=%b step_n=%b, required 1 0", ok, phase_step_n);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if (phase_step_n !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: step_n=%b busy=%b, required 1 0", phase_step_n, busy);
      end
      rst = 1'b0;
      for (int ch = 0; ch < 8; ch++) mdl_ofs[ch] = '0;
      mdl_sel = 3'd0;
      mdl_dir = 1'b0;
      check_offsets("mid_reset");
      run_cmd(3'd2, 1'b1, 8'd3, 1'b0, "after_reset");
      check_one(3'd2, 12'h003, "after_reset");
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_sel   = 3'd0;
      cmd_dir   = 1'b0;
      cmd_steps = 8'd0;
      pll_lock  = 1'b1;
      rd_sel    = 3'd0;
      mdl_sel   = 3'd0;
      mdl_dir   = 1'b0;
      for (int ch = 0; ch < 8; ch++) mdl_ofs[ch] = '0;
      test_reset();
      test_step_advance();
      test_step_retard();
      test_wrap();
      test_timeout();
      test_sel_and_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pll_phase_step_ctrl.md
Name: pll_phase_step_ctrl

Overview:
- Initiator for the PLL dynamic phase-adjust port: PHASE_SEL, PHASE_DIR, PHASE_STEP_N.
- Accepts phase-shift commands over a valid/ready handshake, e.g. retuning the ADC sample-clock phase relative to the capture clock.
- Sequences the required number of active-low step pulses with setup, hold and gap timing, then waits for PLL re-lock with a timeout.
- Keeps a signed accumulated phase offset per PLL output, readable by software.

Parameters:
- NUM_CH, 5, number of PLL outputs addressable (valid cmd_sel 0..NUM_CH-1).
- SETUP_CYC, 2, cycles phase_sel/phase_dir are stable before the first step falling edge.
- LOW_CYC, 4, cycles phase_step_n is held low per step.
- GAP_CYC, 4, cycles phase_step_n is held high between steps and after the last step (hold time).
- LOCK_TO, 50000, maximum cycles spent waiting for pll_lock after the last step.
- OFS_W, 12, width of the signed per-channel offset accumulator.

Ports:
- clk  in  1  system clock (PLL output domain, free-running after lock).
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_sel  in  3  target PLL output index.
- cmd_dir  in  1  1 = advance phase (+), 0 = retard phase (-).
- cmd_steps  in  8  number of 1/8-VCO-period steps; 0 is legal.
- pll_lock  in  1  PLL lock status; asynchronous to clk, synchronised internally by 2 flops.
- phase_sel  out  3  to PLL PHASE_SEL.
- phase_dir  out  1  to PLL PHASE_DIR.
- phase_step_n  out  1  to PLL PHASE_STEP_N, active low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes with lock.
- err_timeout  out  1  one-cycle pulse when the lock wait times out.
- err_sel  out  1  one-cycle pulse when a command with an invalid cmd_sel is rejected.
- rd_sel  in  3  offset readback select.
- rd_offset  out  OFS_W  signed accumulated offset of channel rd_sel, combinational mux; 0 when rd_sel >= NUM_CH.

Behaviour:
- Reset values: phase_step_n=1, phase_sel=0, phase_dir=0, busy=0, done=0, err_timeout=0, err_sel=0, all offsets=0, state=IDLE.
- A reset asserted mid-sequence forces phase_step_n=1 at the next edge. A partial step count is not recorded.
- cmd_ready = (state==IDLE) && lock_sync. No commands are accepted while the PLL is unlocked.
- States: IDLE, SETUP, STEP_LO, STEP_HI, WAIT_LOCK.
- IDLE, on accept:
  - cmd_sel >= NUM_CH: err_sel pulses next cycle; stay in IDLE; outputs unchanged.
  - cmd_steps == 0: done pulses next cycle; stay in IDLE; no pulses; offset unchanged.
  - Otherwise: latch sel/dir/steps, drive phase_sel/phase_dir at that edge, go to SETUP.
- phase_sel and phase_dir are held constant from SETUP until the return to IDLE.
- SETUP: stays SETUP_CYC cycles, then goes to STEP_LO.
- STEP_LO: phase_step_n=0 for exactly LOW_CYC cycles, then goes to STEP_HI and decrements the remaining count.
- STEP_HI: phase_step_n=1 for exactly GAP_CYC cycles. Then:
  - remaining > 0: go to STEP_LO.
  - remaining == 0: go to WAIT_LOCK.
- WAIT_LOCK: timeout counter starts at 0.
  - lock_sync high: done pulses next cycle, go to IDLE.
  - Counter reaches LOCK_TO-1 with lock still low: err_timeout pulses, go to IDLE.
- Offset update: on exit from WAIT_LOCK (either path), offset[sel] += dir ? steps : -steps, modulo 2^OFS_W (two's-complement wrap, no saturation). All steps were physically issued, so the update applies on timeout too.
- pll_lock dropping during SETUP/STEP_LO/STEP_HI is ignored. Stepping completes, then WAIT_LOCK governs.
- Latency with lock already high: accept edge to done pulse = SETUP_CYC + N*(LOW_CYC+GAP_CYC) + 2 cycles.
- The command inputs are ignored while busy. A valid held across a sequence is not double-accepted, because cmd_ready is low.

Test Plan:
- Lock high, rst released, then sel=2, dir=1, steps=3 -> phase_sel=2 and phase_dir=1 stable throughout. First falling edge of phase_step_n 2 cycles after accept. Exactly 3 low pulses of 4 cycles each, separated by 4 high cycles. done pulse at accept+28. rd_sel=2 gives rd_offset=+3.
- Then sel=2, dir=0, steps=5 -> 5 pulses; rd_offset(2)=-2 (0xFFE). Other channels still 0.
- Offset wrap: 8 commands to sel=0, dir=0, steps=255, plus one with steps=8 (total -2048), then one with dir=0, steps=1 -> rd_offset(0) goes 0x800 then 0x7FF.
- pll_lock forced low for the whole sequence, LOCK_TO=100 -> steps complete, then err_timeout pulses exactly 100 cycles after WAIT_LOCK entry. done never asserts. Offset is still updated.
- sel=6 -> err_sel one pulse, no phase_step_n activity. steps=0 on sel=1 -> done next cycle, no pulses. Both commands give cmd_ready=0 while pll_lock is low.
- rst asserted during the 2nd STEP_LO -> phase_step_n=1 the following cycle, busy=0, all offsets=0. A fresh command afterwards behaves as in the first scenario.
